motor_phase_decoder: RTL and testbench

//   Receive-side companion to the stepper-motor pulse distributor: watches the 3-line phase bus y[2:0]
//   and recovers step events, direction and an absolute signed position count.

---
 rtl/motor_pkg.sv | 40 ++++
 rtl/motor_phase_lut.sv | 39 +++
 rtl/motor_phase_decoder.sv | 156 +++++++++++++++
 tb/tb_motor_phase_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the stepper-motor phase decoder and its companions.
// Contents:
//   state_t          decoder FSM states
//   PH_A..PH_CA      phase-bus codes, y[0]=A y[1]=B y[2]=C
//   N3, N6           beats per electrical cycle in three- and six-beat modes
//   phase_dist()     forward distance (idx - last) mod N
package motor_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [2:0] PH_A  = 3'b001;
    localparam logic [2:0] PH_AB = 3'b011;
    localparam logic [2:0] PH_B  = 3'b010;
    localparam logic [2:0] PH_BC = 3'b110;
    localparam logic [2:0] PH_C  = 3'b100;
    localparam logic [2:0] PH_CA = 3'b101;

    localparam int N3 = 3;
    localparam int N6 = 6;

    // Both indices are below N, so a single conditional subtract is enough
    // to fold idx + N - last back into 0..N-1.
    function automatic logic [2:0] phase_dist(input logic [2:0] idx,
                                              input logic [2:0] last,
                                              input logic       six);
        logic [3:0] n;
        logic [3:0] d;
        n = six ? 4'(N6) : 4'(N3);
        d = {1'b0, idx} + n - {1'b0, last};
        if (d >= n) begin
            d = d - n;
        end
        return d[2:0];
    endfunction

endpackage

// File: rtl/motor_phase_lut.sv
// Combinational phase-code lookup, shared with the distributor self-check.
// Ports:
//   code  in  3  phase-bus code (y[0]=A, y[1]=B, y[2]=C)
//   mode  in  1  0 = three-beat, 1 = six-beat
//   idx   out 3  phase index within the cycle (0 when illegal)
//   legal out 1  code is a valid phase in the selected mode
module motor_phase_lut
    import motor_pkg::*;
(
    input  logic [2:0] code,
    input  logic       mode,
    output logic [2:0] idx,
    output logic       legal
);

    always_comb begin
        idx   = 3'd0;
        legal = 1'b0;
        if (mode) begin
            case (code)
                PH_A:    begin idx = 3'd0; legal = 1'b1; end
                PH_AB:   begin idx = 3'd1; legal = 1'b1; end
                PH_B:    begin idx = 3'd2; legal = 1'b1; end
                PH_BC:   begin idx = 3'd3; legal = 1'b1; end
                PH_C:    begin idx = 3'd4; legal = 1'b1; end
                PH_CA:   begin idx = 3'd5; legal = 1'b1; end
                default: begin idx = 3'd0; legal = 1'b0; end
            endcase
        end else begin
            case (code)
                PH_A:    begin idx = 3'd0; legal = 1'b1; end
                PH_B:    begin idx = 3'd1; legal = 1'b1; end
                PH_C:    begin idx = 3'd2; legal = 1'b1; end
                default: begin idx = 3'd0; legal = 1'b0; end
            endcase
        end
    end

endmodule

// File: rtl/motor_phase_decoder.sv
// Recovers step events, direction and a signed absolute position from the
// 3-line stepper phase bus; flags illegal codes and skipped beats.
// Ports:
//   CP      in   1      clock, rising edge
//   CR      in   1      asynchronous active-low reset
//   M       in   1      beat mode: 0 = three-beat, 1 = six-beat
//   y       in   3      phase lines (y[0]=A, y[1]=B, y[2]=C)
//   clr_err in   1      leaves ERROR (unless the current code is illegal)
//   pos     out  POS_W  signed step count, wraps mod 2^POS_W
//   dir     out  1      direction of last step, 1 = forward
//   step    out  1      one-cycle pulse per decoded step
//   locked  out  1      decoder holds a valid reference phase
//   err     out  1      sticky illegal-code / skipped-beat flag
// Build option:
//   DEC_SYNC_EN  adds a two-flop synchroniser on y and M ahead of the input
//                register (latency 4 edges instead of 2).
module motor_phase_decoder
    import motor_pkg::*;
#(
    parameter int POS_W = 16
) (
    input  logic                    CP,
    input  logic                    CR,
    input  logic                    M,
    input  logic [2:0]              y,
    input  logic                    clr_err,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir,
    output logic                    step,
    output logic                    locked,
    output logic                    err
);

    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    logic [2:0] y_p0;
    logic       m_p0;
    logic [2:0] idx_p0;
    logic       legal_p0;
    logic [2:0] dist_p0;
    logic [2:0] back_p0;

    state_t     state;
    logic [2:0] last_idx;
    logic       lock_mode;

    // ---- stage p0: input register (optionally behind a synchroniser) ----
`ifdef DEC_SYNC_EN
    logic [2:0] y_s0, y_s1;
    logic       m_s0, m_s1;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            y_s0 <= 3'd0;
            y_s1 <= 3'd0;
            m_s0 <= 1'b0;
            m_s1 <= 1'b0;
            y_p0 <= 3'd0;
            m_p0 <= 1'b0;
        end else begin
            y_s0 <= y;
            y_s1 <= y_s0;
            m_s0 <= M;
            m_s1 <= m_s0;
            y_p0 <= y_s1;
            m_p0 <= m_s1;
        end
    end
`else
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            y_p0 <= 3'd0;
            m_p0 <= 1'b0;
        end else begin
            y_p0 <= y;
            m_p0 <= M;
        end
    end
`endif

    motor_phase_lut lut_u (
        .code  (y_p0),
        .mode  (m_p0),
        .idx   (idx_p0),
        .legal (legal_p0)
    );

    // Distance is taken in the mode the lock was acquired in; a mode change
    // unlocks before this value is used.
    assign dist_p0 = phase_dist(idx_p0, last_idx, lock_mode);
    assign back_p0 = lock_mode ? 3'(N6 - 1) : 3'(N3 - 1);

    // ---- stage p1: FSM and registered outputs ----
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state     <= ST_UNLOCK;
            last_idx  <= 3'd0;
            lock_mode <= 1'b0;
            pos       <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_UNLOCK: begin
                    // Illegal codes are simply waited out while unlocked.
                    if (legal_p0) begin
                        state     <= ST_LOCKED;
                        locked    <= 1'b1;
                        last_idx  <= idx_p0;
                        lock_mode <= m_p0;
                    end
                end
                ST_LOCKED: begin
                    if (m_p0 != lock_mode) begin
                        // Mode switch: resynchronise rather than flag an error.
                        state  <= ST_UNLOCK;
                        locked <= 1'b0;
                    end else if (!legal_p0) begin
                        state  <= ST_ERROR;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end else if (dist_p0 == 3'd1) begin
                        pos      <= pos + POS_ONE;
                        dir      <= 1'b1;
                        step     <= 1'b1;
                        last_idx <= idx_p0;
                    end else if (dist_p0 == back_p0) begin
                        pos      <= pos - POS_ONE;
                        dir      <= 1'b0;
                        step     <= 1'b1;
                        last_idx <= idx_p0;
                    end else if (dist_p0 != 3'd0) begin
                        state  <= ST_ERROR;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    // An illegal code in the same cycle keeps the error latched.
                    if (clr_err && legal_p0) begin
                        state <= ST_UNLOCK;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_UNLOCK;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_phase_decoder.sv
module tb_motor_phase_decoder;

    localparam int POS_W = 16;
`ifdef DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic                    CP = 1'b0;
    logic                    CR = 1'b0;
    logic                    M = 1'b0;
    logic [2:0]              y = 3'd0;
    logic                    clr_err = 1'b0;
    logic signed [POS_W-1:0] pos;
    logic                    dir, step, locked, err;

    int checks = 0;
    int failures = 0;
    bit use_model = 1'b0;

    always #5 CP = ~CP;

    motor_phase_decoder #(.POS_W(POS_W)) dut (
        .CP      (CP),
        .CR      (CR),
        .M       (M),
        .y       (y),
        .clr_err (clr_err),
        .pos     (pos),
        .dir     (dir),
        .step    (step),
        .locked  (locked),
        .err     (err)
    );

    // ---------------- reference model ----------------
    logic [2:0] six_codes[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    logic [2:0] three_codes[3] = '{3'b001, 3'b010, 3'b100};

    logic [2:0] ydl[LAT];
    logic       mdl[LAT];
    int         st_m;      // 0 unlocked, 1 locked, 2 error
    int         last_m;
    logic       lmode_m;
    int         pos_m;
    logic       dir_m, step_m, err_m;

    function automatic int phase_of(input logic [2:0] c, input logic six);
        if (six) begin
            for (int i = 0; i < 6; i++) if (six_codes[i] == c) return i;
        end else begin
            for (int i = 0; i < 3; i++) if (three_codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LAT; i++) begin
            ydl[i] = 3'd0;
            mdl[i] = 1'b0;
        end
        st_m = 0; last_m = 0; lmode_m = 1'b0; pos_m = 0;
        dir_m = 1'b0; step_m = 1'b0; err_m = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] yq;
        logic       mq;
        int         ix, n, d;
        yq = ydl[LAT-1];
        mq = mdl[LAT-1];
        ix = phase_of(yq, mq);
        step_m = 1'b0;
        if (st_m == 0) begin
            if (ix >= 0) begin st_m = 1; last_m = ix; lmode_m = mq; end
        end else if (st_m == 1) begin
            n = lmode_m ? 6 : 3;
            if (mq != lmode_m) st_m = 0;
            else if (ix < 0) begin st_m = 2; err_m = 1'b1; end
            else begin
                d = (ix - last_m + n) % n;
                if (d == 1) begin
                    pos_m = (pos_m + 1) & 32'hFFFF; dir_m = 1'b1; step_m = 1'b1; last_m = ix;
                end else if (d == n - 1) begin
                    pos_m = (pos_m - 1) & 32'hFFFF; dir_m = 1'b0; step_m = 1'b1; last_m = ix;
                end else if (d != 0) begin
                    st_m = 2; err_m = 1'b1;
                end
            end
        end else begin
            if (clr_err && ix >= 0) begin st_m = 0; err_m = 1'b0; end
        end
        for (int i = LAT - 1; i > 0; i--) begin
            ydl[i] = ydl[i-1];
            mdl[i] = mdl[i-1];
        end
        ydl[0] = y;
        mdl[0] = M;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic s, input logic d,
                              input logic [15:0] p, input logic l, input logic e);
        chk({tag, ".step"},   32'(step),             32'(s));
        chk({tag, ".dir"},    32'(dir),              32'(d));
        chk({tag, ".pos"},    32'($unsigned(pos)),   32'(p));
        chk({tag, ".locked"}, 32'(locked),           32'(l));
        chk({tag, ".err"},    32'(err),              32'(e));
    endtask

    task automatic tick();
        @(posedge CP);
        model_step();
        #1;
        if (use_model) begin
            check_outs("model", step_m, dir_m, pos_m[15:0], (st_m == 1), err_m);
        end
    endtask

    task automatic drive(input logic [2:0] yy, input logic mm, input logic cc);
        @(negedge CP);
        y = yy;
        M = mm;
        clr_err = cc;
    endtask

    task automatic do_reset();
        @(negedge CP);
        CR = 1'b0;
        y = 3'd0;
        M = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(negedge CP);
        CR = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        logic       m;
        logic [2:0] yy;
        logic       clr;
        logic       s;
        logic       d;
        logic [15:0] p;
        logic       l;
        logic       e;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, logic m, logic [2:0] yy, logic c,
                                logic s, logic d, logic [15:0] p, logic l, logic e);
        vec_t v;
        v.rst = r; v.m = m; v.yy = yy; v.clr = c;
        v.s = s; v.d = d; v.p = p; v.l = l; v.e = e;
        return v;
    endfunction

    initial begin
        vec_t       v;
        int         cur_i, n;
        logic [2:0] yy;
        logic       mm;
        int         r;

        model_reset();

        // Forward six-beat cycle
        vt.push_back(mk(1, 0, 3'b000, 0, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 1, 3'b001, 0, 0, 0, 16'h0000, 1, 0));
        vt.push_back(mk(0, 1, 3'b011, 0, 1, 1, 16'h0001, 1, 0));
        vt.push_back(mk(0, 1, 3'b010, 0, 1, 1, 16'h0002, 1, 0));
        vt.push_back(mk(0, 1, 3'b110, 0, 1, 1, 16'h0003, 1, 0));
        vt.push_back(mk(0, 1, 3'b100, 0, 1, 1, 16'h0004, 1, 0));
        vt.push_back(mk(0, 1, 3'b101, 0, 1, 1, 16'h0005, 1, 0));
        vt.push_back(mk(0, 1, 3'b001, 0, 1, 1, 16'h0006, 1, 0));
        // Reverse three-beat, illegal two-hot ignored while unlocked
        vt.push_back(mk(1, 0, 3'b000, 0, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 0, 3'b011, 0, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 0, 3'b100, 0, 0, 0, 16'h0000, 1, 0));
        vt.push_back(mk(0, 0, 3'b010, 0, 1, 0, 16'hFFFF, 1, 0));
        vt.push_back(mk(0, 0, 3'b001, 0, 1, 0, 16'hFFFE, 1, 0));
        vt.push_back(mk(0, 0, 3'b100, 0, 1, 0, 16'hFFFD, 1, 0));
        // Illegal code while locked at pos 5, then clear and relock
        vt.push_back(mk(1, 0, 3'b000, 0, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 0, 3'b010, 0, 0, 0, 16'h0000, 1, 0));
        vt.push_back(mk(0, 0, 3'b100, 0, 1, 1, 16'h0001, 1, 0));
        vt.push_back(mk(0, 0, 3'b001, 0, 1, 1, 16'h0002, 1, 0));
        vt.push_back(mk(0, 0, 3'b010, 0, 1, 1, 16'h0003, 1, 0));
        vt.push_back(mk(0, 0, 3'b100, 0, 1, 1, 16'h0004, 1, 0));
        vt.push_back(mk(0, 0, 3'b001, 0, 1, 1, 16'h0005, 1, 0));
        vt.push_back(mk(0, 0, 3'b111, 0, 0, 1, 16'h0005, 0, 1));
        vt.push_back(mk(0, 0, 3'b010, 1, 0, 1, 16'h0005, 0, 0));
        vt.push_back(mk(0, 0, 3'b010, 0, 0, 1, 16'h0005, 1, 0));
        // Skipped beat; clear blocked by illegal code, then allowed
        vt.push_back(mk(1, 0, 3'b000, 0, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 1, 3'b001, 0, 0, 0, 16'h0000, 1, 0));
        vt.push_back(mk(0, 1, 3'b010, 0, 0, 0, 16'h0000, 0, 1));
        vt.push_back(mk(0, 1, 3'b000, 1, 0, 0, 16'h0000, 0, 1));
        vt.push_back(mk(0, 1, 3'b011, 1, 0, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 1, 3'b011, 0, 0, 0, 16'h0000, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            if (v.rst) begin
                do_reset();
            end else begin
                drive(v.yy, v.m, 1'b0);
                repeat (LAT) tick();
                @(negedge CP);
                clr_err = v.clr;
                tick();
                clr_err = 1'b0;
            end
            check_outs($sformatf("vec%0d", i), v.s, v.d, v.p, v.l, v.e);
        end

        // Positive wrap 0x7FFF -> 0x8000, then mode toggle unlocks quietly
        do_reset();
        drive(3'b001, 1'b0, 1'b0);
        repeat (LAT + 1) tick();
        for (int k = 1; k <= 32767; k++) begin
            drive(three_codes[k % 3], 1'b0, 1'b0);
            tick();
        end
        repeat (LAT) tick();
        check_outs("wrap_pre", 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        drive(three_codes[32768 % 3], 1'b0, 1'b0);
        repeat (LAT + 1) tick();
        check_outs("wrap", 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
        tick();
        chk("wrap_step_pulse", 32'(step), 32'd0);
        drive(three_codes[32768 % 3], 1'b1, 1'b0);
        repeat (LAT + 1) tick();
        check_outs("mode_toggle", 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle
        do_reset();
        drive(3'b001, 1'b1, 1'b0);
        repeat (LAT + 1) tick();
        drive(3'b011, 1'b1, 1'b0);
        repeat (LAT + 1) tick();
        check_outs("pre_async", 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        #2;
        CR = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        model_reset();
        @(negedge CP);
        CR = 1'b1;
        repeat (LAT + 1) tick();
        check_outs("relock", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("relock_nostep", 32'(step), 32'd0);

        // Randomised run against the model
        do_reset();
        use_model = 1'b1;
        cur_i = 0;
        mm = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            n = mm ? 6 : 3;
            r = $urandom_range(0, 99);
            if (r < 75) begin
                cur_i = (cur_i + $urandom_range(0, 2) - 1 + n) % n;
                yy = mm ? six_codes[cur_i] : three_codes[cur_i];
            end else if (r < 85) begin
                yy = 3'($urandom_range(0, 7));
            end else if (r < 88) begin
                mm = ~mm;
                n = mm ? 6 : 3;
                cur_i = cur_i % n;
                yy = mm ? six_codes[cur_i] : three_codes[cur_i];
            end else begin
                cur_i = (cur_i + 2) % n;
                yy = mm ? six_codes[cur_i] : three_codes[cur_i];
            end
            drive(yy, mm, ($urandom_range(0, 7) == 0));
            tick();
        end
        use_model = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
